// File: rtl/fb_scanout_pkg.sv
// Shared definitions for the frame-buffer scanout block: default geometry and FSM encoding.
package fb_scanout_pkg;

  localparam int unsigned DefAddrW     = 17;
  localparam int unsigned DefDataW     = 24;
  localparam int unsigned DefNpix      = 102400;
  localparam int unsigned DefFifoDepth = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSetup   = 2'd1,
    StStrobe  = 2'd2,
    StCapture = 2'd3
  } state_t;

endpackage

// File: rtl/fb_scanout_if.sv
// Frame RAM read port plus the pixel valid/ready stream, bundled for the scanout block.
interface fb_scanout_if import fb_scanout_pkg::*; #(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
);

  logic [ADDR_W-1:0] ram_address;
  logic              ram_rd;
  logic              ram_wr;
  logic              ram_en;
  logic [DATA_W-1:0] ram_data;

  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_last;

  modport master (
    output ram_address, ram_rd, ram_wr, ram_en,
    input  ram_data,
    output pix_data, pix_valid, pix_last,
    input  pix_ready
  );

  modport slave (
    input  ram_address, ram_rd, ram_wr, ram_en,
    output ram_data,
    input  pix_data, pix_valid, pix_last,
    output pix_ready
  );

endinterface

// File: rtl/pix_fifo.sv
// First-word-fall-through pixel buffer; the head entry is visible whenever the FIFO is not empty.
module pix_fifo import fb_scanout_pkg::*; #(
  parameter int unsigned WIDTH = DefDataW + 1,
  parameter int unsigned DEPTH = DefFifoDepth,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [PtrW:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_pop;

  assign do_pop = pop && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !do_pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (!push && do_pop) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

  assign empty    = (count_q == '0);
  assign count    = count_q;
  // Gate the head so an empty buffer never exposes stale storage.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fb_scanout.sv
// Reads one frame from the frame RAM (setup/strobe/capture per pixel) and streams it out.
module fb_scanout import fb_scanout_pkg::*; #(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned NPIX       = DefNpix,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  fb_scanout_if.master bus
);

  localparam int unsigned       CntW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NPIX - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ram_rd, ram_en;
  logic              start_ok, at_last, last_xfer;
  logic              fifo_push, fifo_pop, fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [DATA_W:0]   fifo_out;

  // IDLE with busy still high is the drain phase: start stays ignored until done.
  assign start_ok  = (state_q == StIdle) && !busy_q && start;
  assign at_last   = (addr_q == LastAddr);
  assign fifo_pop  = bus.pix_valid && bus.pix_ready;
  assign last_xfer = fifo_pop && bus.pix_last;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ram_rd    = 1'b0;
    ram_en    = 1'b0;
    fifo_push = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          addr_d  = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        ram_rd = 1'b1;
        if (fifo_count < CntW'(FIFO_DEPTH)) begin
          state_d = StStrobe;
        end
      end
      StStrobe: begin
        ram_rd  = 1'b1;
        ram_en  = 1'b1;
        state_d = StCapture;
      end
      StCapture: begin
        ram_rd    = 1'b1;
        fifo_push = 1'b1;
        if (at_last) begin
          state_d = StIdle;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = StSetup;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    if (start_ok) begin
      busy_d = 1'b1;
    end else if (last_xfer) begin
      busy_d = 1'b0;
    end
    done_d = last_xfer;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  pix_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_pix_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({at_last, bus.ram_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.ram_address = addr_q;
  assign bus.ram_rd      = ram_rd;
  assign bus.ram_wr      = 1'b0;
  assign bus.ram_en      = ram_en;
  assign bus.pix_valid   = !fifo_empty;
  assign bus.pix_data    = fifo_out[DATA_W-1:0];
  assign bus.pix_last    = fifo_out[DATA_W];
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameter ADDR_W, default 17, RAM address width.
REQ-002 Parameter DATA_W, default 24, pixel width (B[23:16], G[15:8], R[7:0]).
REQ-003 Parameter NPIX, default 102400, pixels per frame; legal range 1..2^ADDR_W.
REQ-004 Parameter FIFO_DEPTH, default 4, output buffer entries; power of two, at least 2.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; begins a frame read when idle.
REQ-008 busy  out  1  high from the cycle after accepted start until done.
REQ-009 done  out  1  one-cycle pulse after the last pixel leaves the output.
REQ-010 ram_address  out  ADDR_W  read address to the frame RAM.
REQ-011 ram_rd  out  1  read select.
REQ-012 ram_wr  out  1  write select; constant 0.
REQ-013 ram_en  out  1  access strobe; the RAM acts on its rising edge.
REQ-014 ram_data  in  DATA_W  RAM read data; valid from the second cycle after ram_en rises.
REQ-015 pix_data  out  DATA_W  pixel output.
REQ-016 pix_valid  out  1  pix_data valid.
REQ-017 pix_ready  in  1  consumer accepts; a transfer occurs when valid and ready are both high.
REQ-018 pix_last  out  1  high with the pixel at address NPIX-1.

Function
REQ-019 The FSM shall have four states: IDLE, SETUP, STROBE, CAPTURE.
REQ-020 IDLE: when start=1, ram_address shall load 0 and the FSM shall go to SETUP; start shall be ignored in all other states.
REQ-021 SETUP: ram_rd=1 and ram_en=0; go to STROBE only if FIFO occupancy < FIFO_DEPTH, otherwise stay in SETUP.
REQ-022 STROBE: ram_rd=1 and ram_en=1 for exactly one cycle; then go to CAPTURE.
REQ-023 CAPTURE: ram_en=0; ram_data shall be pushed into the FIFO with a last flag equal to (ram_address==NPIX-1).
REQ-024 On leaving CAPTURE: if the address is NPIX-1, go to IDLE-drain; otherwise increment the address and go to SETUP.
REQ-025 ram_address, ram_rd and ram_wr shall be stable during STROBE and the following cycle.
REQ-026 Throughput shall be one pixel per 3 cycles with no backpressure; there is at most one outstanding RAM read.
REQ-027 Output is first-word-fall-through: pix_valid=1 whenever the FIFO is not empty.
REQ-028 pix_data and pix_last shall hold steady while pix_valid=1 and pix_ready=0.
REQ-029 A push and a pop in the same cycle shall leave occupancy unchanged; push into a full FIFO cannot occur (REQ-021).
REQ-030 done shall pulse in the cycle after the pix_last transfer; busy shall fall in the same cycle.
REQ-031 For NPIX=1, exactly one read and one pixel with pix_last=1 shall occur.
REQ-032 pix_ready=0 indefinitely shall stall the FSM in SETUP with no lost or duplicated pixels.

Reset
REQ-033 While rst=1: FSM=IDLE, ram_address=0, ram_rd=0, ram_wr=0, ram_en=0, FIFO empty, pix_valid=0, pix_last=0, pix_data=0, busy=0, done=0.
REQ-034 Reset mid-frame shall abort immediately and discard buffered pixels; the next start shall restart at address 0.

Structure
REQ-035 A shared package shall hold the FSM state encoding and the default widths (ADDR_W=17, DATA_W=24, NPIX=102400).
REQ-036 The output buffer shall be a sub-module pix_fifo (DATA_W+1 wide, FIFO_DEPTH deep, FWFT, with occupancy output).

Verification
REQ-037 Reset, then start with NPIX=4, RAM preloaded 0x000001..0x000004, pix_ready=1 -> pixels 1..4 in order; pix_last only on 4; done one cycle after it; ram_en high for one cycle every 3 cycles.
REQ-038 NPIX=8 with pix_ready=0 for the first 40 cycles -> exactly FIFO_DEPTH reads issued, then FSM holds in SETUP; after release, all 8 pixels arrive in order, no duplicates.
REQ-039 pix_ready toggling 1/0 each cycle, NPIX=16 -> data matches RAM; pix_data stable while stalled.
REQ-040 rst asserted at pixel 5 of NPIX=16, then start -> outputs at reset values immediately; new frame starts at address 0.
REQ-041 start pulsed while busy -> ignored; single done per frame; ram_wr=0 throughout.
REQ-042 NPIX=1 and NPIX=102400 -> a single pixel with last flag for NPIX=1; for NPIX=102400 the final address is 102399 with pix_last=1.
